lfsr_decrypt_engine: RTL and testbench
======================================

Name: lfsr_decrypt_engine

Overview:
- Hardware decryptor, the counterpart of the program-1 LFSR encryptor.
- Reads the 64-byte parity-tagged ciphertext at data memory [64:127] and recovers the LFSR start state from the space preamble.
- Identifies which of the 9 legal 7-bit tap patterns is in use, then writes the 64 decoded ASCII bytes to data memory [0:63].
- Sits beside DM1 as a memory master and uses the same Start/Ack handshake as TopLevel.

Parameters:
- MSG_LEN, 64, number of ciphertext bytes decoded.
- CT_BASE, 64, data-memory address of ciphertext byte 0.
- PT_BASE, 0, data-memory address of plaintext byte 0.
- PRE_CHK, 9, number of preamble bytes (after byte 0) used to validate a candidate pattern; must be less than the minimum preamble length of 10.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  while high, holds the engine in IDLE; a run begins when it is low in IDLE.
- Ack  out  1  high in DONE.
- MemAddr  out  8  data-memory address; read data is combinational (asynchronous read).
- MemRdData  in  8  data-memory read data for MemAddr.
- MemWrEn  out  1  write strobe; the write commits on the rising Clk edge.
- MemWrData  out  8  write data.
- PtrnIdx  out  4  index 0..8 of the matched tap pattern; 15 if none matched.
- NoMatch  out  1  sticky; set when all 9 patterns fail.
- ParityErrCnt  out  7  count of ciphertext parity errors (see Optional Feature).

Behaviour:
- Reset values: Ack=0, MemWrEn=0, MemAddr=0, MemWrData=0, PtrnIdx=15, NoMatch=0, ParityErrCnt=0; state goes to IDLE. Reset takes effect in any state, including mid-run; writes stop in the same edge.
- LFSR step: next = {s[5:0], ^(s & ptrn)}.
- Tap table, index 0..8: 60, 48, 78, 72, 6A, 69, 5C, 7E, 7B (hex).
- IDLE: MemAddr=CT_BASE. If Start=0 at an edge, go to SEED.
- SEED (1 cycle): seed <= MemRdData[6:0]; lfsr <= seed value; p <= 0; k <= 1. Go to SEARCH.
  - Seed of 0 is legal; it decodes to an all-0 state and sets NoMatch.
- SEARCH (1 cycle per compared byte):
  - MemAddr = CT_BASE+k; compare step(lfsr, tap[p]) with MemRdData[6:0].
  - Match and k=PRE_CHK: PtrnIdx <= p; lfsr <= seed; i <= 0; go to DECODE.
  - Match and k<PRE_CHK: lfsr <= step(lfsr); k++.
  - Mismatch and p<8: p++, k <= 1, lfsr <= seed.
  - Mismatch and p=8: NoMatch <= 1; go to DONE. Nothing is written.
- DECODE (1 cycle per byte, MSG_LEN cycles):
  - MemAddr = CT_BASE+i for the read.
  - Write PT_BASE+i with MemWrData = {1'b0, MemRdData[6:0] ^ lfsr} + 8'h20, using 8-bit wrap arithmetic.
  - Single-port sharing: the address mux drives the write address on the write cycle. Therefore each byte takes 2 cycles (read-latch, then write); DECODE totals 2*MSG_LEN cycles.
  - After each write, lfsr <= step(lfsr, tap[PtrnIdx]).
  - After byte MSG_LEN-1, go to DONE.
- DONE: Ack=1, MemWrEn=0. Stay in DONE while Start=0. When Start=1, return to IDLE and drop Ack on that edge. PtrnIdx and NoMatch hold until the next SEED.
- Start rising during SEED, SEARCH or DECODE is ignored; the run completes.
- Latency with p=0 matched: 1 (SEED) + 9 + 128 edges from the run-start edge until Ack=1.

Optional Feature:
- Macro DECRYPT_PARITY_EN.
- Defined: in each DECODE read cycle, if MemRdData[7] != ^MemRdData[6:0], ParityErrCnt increments (saturates at 127). It clears at SEED. Decoding proceeds regardless.
- Undefined: no checker logic; ParityErrCnt is constant 0.

Decomposition:
- Package lfsr_pkg:
  - TAP_TABLE[9] 7-bit constant array.
  - typedef enum logic[2:0] {IDLE, SEED, SEARCH, DECODE, DONE} dec_state_t.
  - ASCII_OFFSET = 8'h20.
  - function lfsr_step(s, ptrn).
- One natural sub-module: lfsr7_step, the combinational next-state with 7-bit in, 7-bit taps, 7-bit out. It is shared with any future encryptor.

Test Plan:
- "Mr. Watson, come here. I want to see you.", pre_length 13, taps 7B, init 01, encrypted by a bench model into mem[64:127] -> PtrnIdx=8, NoMatch=0, mem[13]=0x4D, mem[0..12]=0x20, Ack high, ParityErrCnt=0.
- Same message with taps 60, init 7F, pre_length 10 -> PtrnIdx=0; all 64 bytes match the padded plaintext.
- Ciphertext built with non-legal taps 41 -> NoMatch=1, PtrnIdx=15, mem[0:63] unchanged, Ack high.
- Flip bit7 of mem[70] and mem[100] with DECRYPT_PARITY_EN defined -> ParityErrCnt=2 and decode still correct. Without the macro -> 0.
- Reset asserted for 1 cycle during DECODE at i=30 -> next cycle IDLE, Ack=0, MemWrEn=0. A restart with Start low completes correctly.
- Start held high 50 cycles -> no memory access; MemWrEn stays 0. After DONE, raise Start -> Ack falls on that edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR decryptor (and any future matching encryptor).
// Holds the legal tap table, buffer geometry, the ASCII offset, the FSM state
// type and the single-step LFSR function.
// Optional feature macro used by the engine: DECRYPT_PARITY_EN.
package lfsr_pkg;

  localparam int MSG_LEN  = 64;
  localparam int CT_BASE  = 64;
  localparam int PT_BASE  = 0;
  localparam int PRE_CHK  = 9;
  localparam int NUM_PTRN = 9;

  localparam logic [7:0] ASCII_OFFSET = 8'h20;
  localparam logic [3:0] PTRN_NONE    = 4'd15;

  localparam logic [6:0] TAP_TABLE [NUM_PTRN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECODE, DONE} dec_state_t;

  // Shift left, feed the parity of the tapped bits into bit 0.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] ptrn);
    return {s[5:0], ^(s & ptrn)};
  endfunction

  // Table lookup that tolerates out-of-range indices (returns all-zero taps).
  function automatic logic [6:0] tap_lookup(input logic [3:0] idx);
    logic [6:0] t;
    t = '0;
    for (int j = 0; j < NUM_PTRN; j++) begin
      if (idx == 4'(j)) t = TAP_TABLE[j];
    end
    return t;
  endfunction

endpackage

// File: rtl/lfsr7_step.sv
// Combinational 7-bit LFSR next-state.
// Ports:
//   state_i  current 7-bit LFSR state
//   taps_i   7-bit tap pattern
//   next_o   state after one step
module lfsr7_step
  import lfsr_pkg::*;
(
  input  logic [6:0] state_i,
  input  logic [6:0] taps_i,
  output logic [6:0] next_o
);

  assign next_o = lfsr_step(state_i, taps_i);

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// LFSR decryptor: memory master that reads 64 parity-tagged ciphertext bytes,
// recovers the LFSR seed from the space preamble, identifies which of the 9
// legal tap patterns was used, and writes the decoded ASCII message back.
// Ports:
//   Clk           clock, rising edge
//   Reset         synchronous active-high reset
//   Start         high holds the engine in IDLE; low in IDLE starts a run
//   Ack           high while in DONE
//   MemAddr       data-memory address (asynchronous read)
//   MemRdData     read data for MemAddr
//   MemWrEn       write strobe, commits on the rising edge
//   MemWrData     write data
//   PtrnIdx       matched tap index 0..8, 15 when none matched
//   NoMatch       sticky flag, set when every pattern fails
//   ParityErrCnt  ciphertext parity errors seen while decoding
// Build option: define DECRYPT_PARITY_EN to enable the parity checker;
// otherwise ParityErrCnt is tied to 0.
module lfsr_decrypt_engine
  import lfsr_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  output logic [3:0] PtrnIdx,
  output logic       NoMatch,
  output logic [6:0] ParityErrCnt
);

  localparam logic [7:0] CT_ADDR = 8'(CT_BASE);
  localparam logic [7:0] PT_ADDR = 8'(PT_BASE);
  localparam logic [3:0] LAST_K  = 4'(PRE_CHK);
  localparam logic [3:0] LAST_P  = 4'(NUM_PTRN - 1);
  localparam logic [5:0] LAST_I  = 6'(MSG_LEN - 1);

  dec_state_t state_q, state_d;
  logic [6:0] seed_q, seed_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [3:0] p_q, p_d;
  logic [3:0] k_q, k_d;
  logic [5:0] i_q, i_d;
  logic       wrPhase_q, wrPhase_d;
  logic [3:0] ptrnIdx_q, ptrnIdx_d;
  logic       noMatch_q, noMatch_d;
  logic       ack_q, ack_d;
  logic [7:0] memAddr_q, memAddr_d;
  logic       memWrEn_q, memWrEn_d;
  logic [7:0] memWrData_q, memWrData_d;

  logic [6:0] stepTaps;
  logic [6:0] lfsrNext;
  logic       searchHit;
  logic [7:0] decodedByte;

  // During the search the candidate pattern drives the step; once decoding,
  // the matched pattern does.
  assign stepTaps = (state_q == DECODE) ? tap_lookup(ptrnIdx_q) : tap_lookup(p_q);

  lfsr7_step u_step (
    .state_i (lfsr_q),
    .taps_i  (stepTaps),
    .next_o  (lfsrNext)
  );

  // A zero seed locks the LFSR at zero, so no pattern can be identified from
  // it; treat every comparison as a miss so the run ends with NoMatch.
  assign searchHit   = (lfsrNext == MemRdData[6:0]) && (seed_q != 7'd0);
  assign decodedByte = {1'b0, MemRdData[6:0] ^ lfsr_q} + ASCII_OFFSET;

  // Memory outputs are registered: each transition loads the address and
  // strobe for the cycle that follows. In DECODE this gives a read cycle
  // (ciphertext address, data latched) then a write cycle (plaintext address).
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    p_d         = p_q;
    k_d         = k_q;
    i_d         = i_q;
    wrPhase_d   = wrPhase_q;
    ptrnIdx_d   = ptrnIdx_q;
    noMatch_d   = noMatch_q;
    ack_d       = ack_q;
    memAddr_d   = memAddr_q;
    memWrEn_d   = 1'b0;
    memWrData_d = memWrData_q;

    case (state_q)
      IDLE: begin
        memAddr_d = CT_ADDR;
        ack_d     = 1'b0;
        if (!Start) state_d = SEED;
      end

      SEED: begin
        seed_d    = MemRdData[6:0];
        lfsr_d    = MemRdData[6:0];
        p_d       = 4'd0;
        k_d       = 4'd1;
        ptrnIdx_d = PTRN_NONE;
        noMatch_d = 1'b0;
        memAddr_d = CT_ADDR + 8'd1;
        state_d   = SEARCH;
      end

      SEARCH: begin
        if (searchHit) begin
          if (k_q == LAST_K) begin
            ptrnIdx_d = p_q;
            lfsr_d    = seed_q;
            i_d       = 6'd0;
            wrPhase_d = 1'b0;
            memAddr_d = CT_ADDR;
            state_d   = DECODE;
          end else begin
            lfsr_d    = lfsrNext;
            k_d       = k_q + 4'd1;
            memAddr_d = CT_ADDR + {4'b0000, k_q} + 8'd1;
          end
        end else if (p_q != LAST_P) begin
          p_d       = p_q + 4'd1;
          k_d       = 4'd1;
          lfsr_d    = seed_q;
          memAddr_d = CT_ADDR + 8'd1;
        end else begin
          noMatch_d = 1'b1;
          ack_d     = 1'b1;
          memAddr_d = CT_ADDR;
          state_d   = DONE;
        end
      end

      DECODE: begin
        if (!wrPhase_q) begin
          memWrData_d = decodedByte;
          memWrEn_d   = 1'b1;
          memAddr_d   = PT_ADDR + {2'b00, i_q};
          wrPhase_d   = 1'b1;
        end else begin
          lfsr_d    = lfsrNext;
          wrPhase_d = 1'b0;
          if (i_q == LAST_I) begin
            ack_d     = 1'b1;
            memAddr_d = CT_ADDR;
            state_d   = DONE;
          end else begin
            i_d       = i_q + 6'd1;
            memAddr_d = CT_ADDR + {2'b00, i_q} + 8'd1;
          end
        end
      end

      DONE: begin
        ack_d = 1'b1;
        if (Start) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      seed_q      <= 7'd0;
      lfsr_q      <= 7'd0;
      p_q         <= 4'd0;
      k_q         <= 4'd0;
      i_q         <= 6'd0;
      wrPhase_q   <= 1'b0;
      ptrnIdx_q   <= PTRN_NONE;
      noMatch_q   <= 1'b0;
      ack_q       <= 1'b0;
      memAddr_q   <= 8'd0;
      memWrEn_q   <= 1'b0;
      memWrData_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      p_q         <= p_d;
      k_q         <= k_d;
      i_q         <= i_d;
      wrPhase_q   <= wrPhase_d;
      ptrnIdx_q   <= ptrnIdx_d;
      noMatch_q   <= noMatch_d;
      ack_q       <= ack_d;
      memAddr_q   <= memAddr_d;
      memWrEn_q   <= memWrEn_d;
      memWrData_q <= memWrData_d;
    end
  end

`ifdef DECRYPT_PARITY_EN
  logic [6:0] parityErrCnt_q;

  // Bit 7 of each ciphertext byte is the XOR of bits 6:0; count violations on
  // the DECODE read cycles only, saturating rather than wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      parityErrCnt_q <= 7'd0;
    end else if (state_q == SEED) begin
      parityErrCnt_q <= 7'd0;
    end else if ((state_q == DECODE) && !wrPhase_q &&
                 (MemRdData[7] != ^MemRdData[6:0]) && (parityErrCnt_q != 7'd127)) begin
      parityErrCnt_q <= parityErrCnt_q + 7'd1;
    end
  end

  assign ParityErrCnt = parityErrCnt_q;
`else
  logic unusedRdMsb;
  assign unusedRdMsb  = MemRdData[7];
  assign ParityErrCnt = 7'd0;
`endif

  assign Ack       = ack_q;
  assign MemAddr   = memAddr_q;
  assign MemWrEn   = memWrEn_q;
  assign MemWrData = memWrData_q;
  assign PtrnIdx   = ptrnIdx_q;
  assign NoMatch   = noMatch_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Testbench for lfsr_decrypt_engine: a behavioural data memory, a ciphertext
// generator and a brute-force reference decryptor.
module tb_lfsr_decrypt_engine;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b1;
  logic       Ack;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [3:0] PtrnIdx;
  logic       NoMatch;
  logic [6:0] ParityErrCnt;

  lfsr_decrypt_engine dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Ack          (Ack),
    .MemAddr      (MemAddr),
    .MemRdData    (MemRdData),
    .MemWrEn      (MemWrEn),
    .MemWrData    (MemWrData),
    .PtrnIdx      (PtrnIdx),
    .NoMatch      (NoMatch),
    .ParityErrCnt (ParityErrCnt)
  );

  always #5 Clk = ~Clk;

  // Data memory: asynchronous read, write on the rising edge; the bench loads
  // a whole image through loadReq so only this block writes the array.
  logic [7:0] mem   [256];
  logic [7:0] image [256];
  logic       loadReq    = 1'b0;
  int         writeCount = 0;

  assign MemRdData = mem[MemAddr];

  always @(posedge Clk) begin
    if (loadReq) begin
      mem <= image;
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
      writeCount   <= writeCount + 1;
    end
  end

  int nCompared   = 0;
  int nMismatched = 0;

  localparam logic [6:0] TAPS [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };
  localparam string WATSON = "Mr. Watson, come here. I want to see you.";

  logic [7:0] plain  [64];
  logic [7:0] ct     [64];
  logic [7:0] expMem [64];
  int         expPtrn;
  bit         expNoMatch;
  int         expLat;
  int         expParity;

  function automatic logic [6:0] mstep(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // Padded plaintext: pre spaces, the message, then spaces to 64 bytes.
  task automatic buildPlain(input string msg, input int pre);
    for (int j = 0; j < 64; j++) begin
      if (j < pre || (j - pre) >= msg.len()) plain[j] = 8'h20;
      else plain[j] = msg[j - pre];
    end
  endtask

  // Encryptor: (char - 0x20) XOR lfsr state, bit 7 carries the parity tag.
  task automatic encrypt(input logic [6:0] t, input logic [6:0] init);
    logic [6:0] s;
    logic [6:0] c;
    s = init;
    for (int j = 0; j < 64; j++) begin
      c     = 7'(plain[j] - 8'h20) ^ s;
      ct[j] = {^c, c};
      s     = mstep(s, t);
    end
  endtask

  // Load ciphertext plus a random sentinel plaintext area, then predict the
  // outcome by trying every legal pattern against the preamble.
  task automatic loadAndModel();
    logic [6:0] s;
    bit         hit;
    for (int a = 0; a < 256; a++) image[a] = 8'h00;
    for (int j = 0; j < 64; j++) begin
      image[j]      = 8'($urandom);
      image[64 + j] = ct[j];
    end
    expPtrn   = 15;
    expLat    = 1;
    expParity = 0;
    for (int p = 0; p < 9; p++) begin
      if (expPtrn == 15) begin
        s   = ct[0][6:0];
        hit = 1'b1;
        for (int k = 1; k <= 9; k++) begin
          if (hit) begin
            s = mstep(s, TAPS[p]);
            expLat++;
            if (s != ct[k][6:0]) hit = 1'b0;
          end
        end
        if (hit) expPtrn = p;
      end
    end
    expNoMatch = (expPtrn == 15);
    if (!expNoMatch) begin
      s = ct[0][6:0];
      for (int j = 0; j < 64; j++) begin
        expMem[j] = {1'b0, ct[j][6:0] ^ s} + 8'h20;
        s = mstep(s, TAPS[expPtrn]);
`ifdef DECRYPT_PARITY_EN
        if (ct[j][7] != ^ct[j][6:0]) expParity++;
`endif
      end
      expLat += 128;
    end else begin
      for (int j = 0; j < 64; j++) expMem[j] = image[j];
    end
    @(negedge Clk);
    loadReq = 1'b1;
    @(negedge Clk);
    loadReq = 1'b0;
  endtask

  // Drop Start and count edges until Ack; lat is edges after the run-start edge.
  task automatic runDecrypt(output int lat, output bit timedOut);
    int cycles;
    cycles   = 0;
    timedOut = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    while (cycles < 2000) begin
      @(posedge Clk);
      #1;
      cycles++;
      if (Ack === 1'b1) begin
        timedOut = 1'b0;
        break;
      end
    end
    lat = cycles - 1;
  endtask

  task automatic releaseDone();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    nCompared++; if (Ack !== 1'b0) begin nMismatched++; $display("FAIL reset_ack: got %b want 0", Ack); end
    nCompared++; if (MemWrEn !== 1'b0) begin nMismatched++; $display("FAIL reset_wren: got %b want 0", MemWrEn); end
    nCompared++; if (MemAddr !== 8'h00) begin nMismatched++; $display("FAIL reset_addr: got %h want 00", MemAddr); end
    nCompared++; if (MemWrData !== 8'h00) begin nMismatched++; $display("FAIL reset_wdata: got %h want 00", MemWrData); end
    nCompared++; if (PtrnIdx !== 4'd15) begin nMismatched++; $display("FAIL reset_ptrn: got %0d want 15", PtrnIdx); end
    nCompared++; if (NoMatch !== 1'b0) begin nMismatched++; $display("FAIL reset_nomatch: got %b want 0", NoMatch); end
    nCompared++; if (ParityErrCnt !== 7'd0) begin nMismatched++; $display("FAIL reset_parity: got %0d want 0", ParityErrCnt); end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    nCompared++; if (MemAddr !== 8'd64) begin nMismatched++; $display("FAIL idle_addr: got %h want 40", MemAddr); end
  endtask

  task automatic test_watson();
    int lat;
    bit to;
    buildPlain(WATSON, 13);
    encrypt(7'h7B, 7'h01);
    loadAndModel();
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL watson_ack: no Ack within bound"); end
    nCompared++; if (PtrnIdx !== 4'd8) begin nMismatched++; $display("FAIL watson_ptrn: got %0d want 8", PtrnIdx); end
    nCompared++; if (NoMatch !== 1'b0) begin nMismatched++; $display("FAIL watson_nomatch: got %b want 0", NoMatch); end
    nCompared++; if (mem[13] !== 8'h4D) begin nMismatched++; $display("FAIL watson_m: got %h want 4d", mem[13]); end
    for (int j = 0; j < 13; j++) begin
      nCompared++; if (mem[j] !== 8'h20) begin nMismatched++; $display("FAIL watson_pre[%0d]: got %h want 20", j, mem[j]); end
    end
    for (int j = 0; j < 64; j++) begin
      nCompared++; if (mem[j] !== plain[j]) begin nMismatched++; $display("FAIL watson_pt[%0d]: got %h want %h", j, mem[j], plain[j]); end
    end
    nCompared++; if (ParityErrCnt !== 7'd0) begin nMismatched++; $display("FAIL watson_parity: got %0d want 0", ParityErrCnt); end
    nCompared++; if (lat !== expLat) begin nMismatched++; $display("FAIL watson_latency: got %0d want %0d", lat, expLat); end
    releaseDone();
  endtask

  task automatic test_taps60();
    int lat;
    bit to;
    buildPlain(WATSON, 10);
    encrypt(7'h60, 7'h7F);
    loadAndModel();
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL t60_ack: no Ack within bound"); end
    nCompared++; if (PtrnIdx !== 4'd0) begin nMismatched++; $display("FAIL t60_ptrn: got %0d want 0", PtrnIdx); end
    for (int j = 0; j < 64; j++) begin
      nCompared++; if (mem[j] !== plain[j]) begin nMismatched++; $display("FAIL t60_pt[%0d]: got %h want %h", j, mem[j], plain[j]); end
    end
    nCompared++; if (lat !== 138) begin nMismatched++; $display("FAIL t60_latency: got %0d want 138", lat); end
    releaseDone();
  endtask

  task automatic test_parity();
    int lat;
    bit to;
    buildPlain(WATSON, 13);
    encrypt(7'h7B, 7'h01);
    ct[6][7]  = ~ct[6][7];
    ct[36][7] = ~ct[36][7];
    loadAndModel();
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL parity_ack: no Ack within bound"); end
`ifdef DECRYPT_PARITY_EN
    nCompared++; if (ParityErrCnt !== 7'd2) begin nMismatched++; $display("FAIL parity_cnt: got %0d want 2", ParityErrCnt); end
`else
    nCompared++; if (ParityErrCnt !== 7'd0) begin nMismatched++; $display("FAIL parity_cnt: got %0d want 0", ParityErrCnt); end
`endif
    for (int j = 0; j < 64; j++) begin
      nCompared++; if (mem[j] !== plain[j]) begin nMismatched++; $display("FAIL parity_pt[%0d]: got %h want %h", j, mem[j], plain[j]); end
    end
    releaseDone();
  endtask

  task automatic test_no_match();
    int lat;
    bit to;
    int wc0;
    buildPlain(WATSON, 13);
    encrypt(7'h41, 7'h01);
    loadAndModel();
    wc0 = writeCount;
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL nomatch_ack: no Ack within bound"); end
    nCompared++; if (NoMatch !== 1'b1) begin nMismatched++; $display("FAIL nomatch_flag: got %b want 1", NoMatch); end
    nCompared++; if (PtrnIdx !== 4'd15) begin nMismatched++; $display("FAIL nomatch_ptrn: got %0d want 15", PtrnIdx); end
    nCompared++; if (writeCount !== wc0) begin nMismatched++; $display("FAIL nomatch_writes: got %0d want %0d", writeCount, wc0); end
    for (int j = 0; j < 64; j++) begin
      nCompared++; if (mem[j] !== expMem[j]) begin nMismatched++; $display("FAIL nomatch_mem[%0d]: got %h want %h", j, mem[j], expMem[j]); end
    end
    nCompared++; if (ParityErrCnt !== 7'd0) begin nMismatched++; $display("FAIL nomatch_parity: got %0d want 0", ParityErrCnt); end
    nCompared++; if (lat !== expLat) begin nMismatched++; $display("FAIL nomatch_latency: got %0d want %0d", lat, expLat); end
    releaseDone();
  endtask

  task automatic test_reset_mid_decode();
    int  lat;
    bit  to;
    bit  found;
    buildPlain(WATSON, 10);
    encrypt(7'h60, 7'h7F);
    loadAndModel();
    found = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!found) begin
        @(posedge Clk);
        #1;
        if (MemWrEn === 1'b1 && MemAddr === 8'd30) found = 1'b1;
      end
    end
    nCompared++; if (!found) begin nMismatched++; $display("FAIL midreset_reach: write of byte 30 not seen"); end
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    nCompared++; if (Ack !== 1'b0) begin nMismatched++; $display("FAIL midreset_ack: got %b want 0", Ack); end
    nCompared++; if (MemWrEn !== 1'b0) begin nMismatched++; $display("FAIL midreset_wren: got %b want 0", MemWrEn); end
    nCompared++; if (MemAddr !== 8'h00) begin nMismatched++; $display("FAIL midreset_addr: got %h want 00", MemAddr); end
    nCompared++; if (PtrnIdx !== 4'd15) begin nMismatched++; $display("FAIL midreset_ptrn: got %0d want 15", PtrnIdx); end
    loadAndModel();
    @(negedge Clk);
    Reset = 1'b0;
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL midreset_restart: no Ack within bound"); end
    nCompared++; if (PtrnIdx !== 4'd0) begin nMismatched++; $display("FAIL midreset_ptrn2: got %0d want 0", PtrnIdx); end
    for (int j = 0; j < 64; j++) begin
      nCompared++; if (mem[j] !== plain[j]) begin nMismatched++; $display("FAIL midreset_pt[%0d]: got %h want %h", j, mem[j], plain[j]); end
    end
    releaseDone();
  endtask

  task automatic test_start_held();
    int lat;
    bit to;
    int wc0;
    wc0 = writeCount;
    @(negedge Clk);
    Start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge Clk);
      #1;
      nCompared++; if (MemWrEn !== 1'b0 || Ack !== 1'b0) begin nMismatched++; $display("FAIL held_idle[%0d]: wren %b ack %b want 0 0", c, MemWrEn, Ack); end
    end
    nCompared++; if (writeCount !== wc0) begin nMismatched++; $display("FAIL held_writes: got %0d want %0d", writeCount, wc0); end
    buildPlain(WATSON, 11);
    encrypt(7'h5C, 7'h33);
    loadAndModel();
    runDecrypt(lat, to);
    nCompared++; if (to) begin nMismatched++; $display("FAIL held_run: no Ack within bound"); end
    @(negedge Clk);
    nCompared++; if (Ack !== 1'b1) begin nMismatched++; $display("FAIL held_done_ack: got %b want 1", Ack); end
    Start = 1'b1;
    @(posedge Clk);
    #1;
    nCompared++; if (Ack !== 1'b0) begin nMismatched++; $display("FAIL held_ack_fall: got %b want 0", Ack); end
    nCompared++; if (PtrnIdx !== 4'(expPtrn)) begin nMismatched++; $display("FAIL held_ptrn_hold: got %0d want %0d", PtrnIdx, expPtrn); end
  endtask

  task automatic test_random();
    int         lat;
    bit         to;
    int         tIdx;
    int         pre;
    logic [6:0] init;
    int         nFlip;
    int         pos;
    for (int n = 0; n < 8; n++) begin
      tIdx = $urandom_range(0, 8);
      init = 7'($urandom_range(1, 127));
      pre  = $urandom_range(10, 20);
      for (int j = 0; j < 64; j++) begin
        if (j < pre) plain[j] = 8'h20;
        else plain[j] = 8'($urandom_range(32, 126));
      end
      encrypt(TAPS[tIdx], init);
      nFlip = $urandom_range(0, 3);
      for (int f = 0; f < nFlip; f++) begin
        pos = $urandom_range(0, 63);
        ct[pos][7] = ~ct[pos][7];
      end
      loadAndModel();
      runDecrypt(lat, to);
      nCompared++; if (to) begin nMismatched++; $display("FAIL rnd%0d_ack: no Ack within bound", n); end
      nCompared++; if (PtrnIdx !== 4'(expPtrn)) begin nMismatched++; $display("FAIL rnd%0d_ptrn: got %0d want %0d", n, PtrnIdx, expPtrn); end
      nCompared++; if (NoMatch !== expNoMatch) begin nMismatched++; $display("FAIL rnd%0d_nomatch: got %b want %b", n, NoMatch, expNoMatch); end
      nCompared++; if (ParityErrCnt !== 7'(expParity)) begin nMismatched++; $display("FAIL rnd%0d_parity: got %0d want %0d", n, ParityErrCnt, expParity); end
      nCompared++; if (lat !== expLat) begin nMismatched++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, expLat); end
      for (int j = 0; j < 64; j++) begin
        nCompared++; if (mem[j] !== expMem[j]) begin nMismatched++; $display("FAIL rnd%0d_mem[%0d]: got %h want %h", n, j, mem[j], expMem[j]); end
      end
      releaseDone();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_watson();
    test_taps60();
    test_parity();
    test_no_match();
    test_reset_mid_decode();
    test_start_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
